// File: rtl/fifo_uart_tx_pkg.sv
// fifo_uart_tx_pkg: state encoding, parity types and line levels for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
endpackage

// File: rtl/uart_tx_parity_calc.sv
// uart_tx_parity_calc: parity bit for a payload, even or odd.
module uart_tx_parity_calc
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_o
);
  assign par_o = par_typ_i == PAR_ODD ? ~^data_i : ^data_i;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from the async FIFO read side and serialises them as UART frames.
// Defining FIFO_UART_TX_PRESCALE_EN adds i_prescale, stretching every bit period to that many cycles.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      i_empty,
  input  logic [DATA_WIDTH-1:0]     i_rdata,
  input  logic                      i_par_en,
  input  logic                      i_par_typ,
`ifdef FIFO_UART_TX_PRESCALE_EN
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
`endif
  output logic                      o_rinc,
  output logic                      o_tx_out,
  output logic                      o_busy
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] presc_in, presc_q, presc_d, pcnt_q, pcnt_d;
  logic par_en_q, par_en_d, par_bit_q, par_bit_d, par_calc;
  logic tx_q, tx_d, busy_q, busy_d;
  logic load, bit_end, last_bit;
`ifdef FIFO_UART_TX_PRESCALE_EN
  assign presc_in = i_prescale;
`else
  assign presc_in = PRESCALE_WIDTH'(1);
`endif
  assign bit_end  = pcnt_q == presc_q - PRESCALE_WIDTH'(1);
  assign last_bit = cnt_q == CW'(DATA_WIDTH - 1);
  assign load     = RST && !i_empty && (state_q == IDLE || (state_q == STOP && bit_end));
  assign o_rinc   = load;
  assign o_tx_out = tx_q;
  assign o_busy   = busy_q;
  // Parity is resolved at load so later config changes cannot reach the frame.
  uart_tx_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data_i   (i_rdata),
    .par_typ_i(i_par_typ),
    .par_o    (par_calc)
  );
  always_ff @(posedge CLK) state_q <= !RST ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load ? START : IDLE;
      START:   state_d = bit_end ? DATA : START;
      DATA:    state_d = bit_end && last_bit ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = bit_end ? STOP : PARITY;
      STOP:    state_d = bit_end ? (load ? START : IDLE) : STOP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    shift_d   = load ? i_rdata : (state_q == DATA && bit_end) ? shift_q >> 1 : shift_q;
    cnt_d     = (state_q == DATA && bit_end) ? (last_bit ? '0 : cnt_q + CW'(1)) : cnt_q;
    pcnt_d    = (state_q == IDLE || bit_end) ? '0 : pcnt_q + PRESCALE_WIDTH'(1);
    presc_d   = load ? (presc_in == '0 ? PRESCALE_WIDTH'(1) : presc_in) : presc_q;
    par_en_d  = load ? i_par_en : par_en_q;
    par_bit_d = load ? par_calc : par_bit_q;
    tx_d      = state_d == START  ? START_LVL :
                state_d == DATA   ? shift_d[0] :
                state_d == PARITY ? par_bit_q : IDLE_LVL;
    busy_d    = state_d != IDLE;
  end
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shift_q   <= '0;
      cnt_q     <= '0;
      pcnt_q    <= '0;
      presc_q   <= PRESCALE_WIDTH'(1);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= IDLE_LVL;
      busy_q    <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      pcnt_q    <= pcnt_d;
      presc_q   <= presc_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: line-schedule model of fifo_uart_tx with directed literal checks and random traffic.
module tb_fifo_uart_tx;
  localparam int DW = 8;
  localparam int PW = 6;
  logic clk = 0, rst_n = 0, i_empty = 1, i_par_en = 0, i_par_typ = 0;
  logic [DW-1:0] i_rdata = '0;
`ifdef FIFO_UART_TX_PRESCALE_EN
  logic [PW-1:0] i_prescale = 1;
`endif
  logic o_rinc, o_tx_out, o_busy;
  int errors = 0, checks = 0;
  logic line_q[$];
  bit seen_rst = 0;
  logic samp[128];
  int busy_n;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
    .CLK      (clk),
    .RST      (rst_n),
    .i_empty  (i_empty),
    .i_rdata  (i_rdata),
    .i_par_en (i_par_en),
    .i_par_typ(i_par_typ),
`ifdef FIFO_UART_TX_PRESCALE_EN
    .i_prescale(i_prescale),
`endif
    .o_rinc   (o_rinc),
    .o_tx_out (o_tx_out),
    .o_busy   (o_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int presc_eff();
`ifdef FIFO_UART_TX_PRESCALE_EN
    return i_prescale == 0 ? 1 : int'(i_prescale);
`else
    return 1;
`endif
  endfunction

  // The model is a schedule of future line levels; front is the current cycle.
  function automatic void push_frame(input logic [DW-1:0] d, input logic pe, input logic pt, input int p);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? ~^d : ^d);
    bits.push_back(1'b1);
    foreach (bits[k]) for (int r = 0; r < p; r++) line_q.push_back(bits[k]);
  endfunction

  always @(posedge clk) begin
    bit pop;
    pop = rst_n && !i_empty && line_q.size() <= 1;
    if (line_q.size() != 0) void'(line_q.pop_front());
    if (!rst_n) begin
      line_q.delete();
      seen_rst = 1;
    end else if (pop) push_frame(i_rdata, i_par_en, i_par_typ, presc_eff());
  end

  always @(negedge clk) if (seen_rst) begin
    check("rinc", o_rinc, rst_n && !i_empty && line_q.size() <= 1);
    check("tx", o_tx_out, line_q.size() != 0 ? line_q[0] : 1'b1);
    check("busy", o_busy, line_q.size() != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_byte(input logic [DW-1:0] d, input logic pe, input logic pt);
    bit ok = 0;
    i_rdata = d; i_par_en = pe; i_par_typ = pt; i_empty = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (o_rinc === 1'b1) ok = 1;
    end
    check("pop_wait", ok, 1);
    tick();
    i_empty = 1;
  endtask

  task automatic record(input int n);
    busy_n = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      samp[i] = o_tx_out;
      busy_n += (o_busy === 1'b1) ? 1 : 0;
    end
    tick();
  endtask

  function automatic logic [31:0] packed_samp(input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], samp[i]};
    return v;
  endfunction

  initial begin
    int n, pops;
    bit ok;
    repeat (3) tick();
    rst_n = 1;
    // Idle line with an empty FIFO
    record(20);
    check("idle_busy", busy_n, 0);
    check("idle_line", packed_samp(20), 32'h000F_FFFF);
    // 0xA5 no parity: 0,1,0,1,0,0,1,0,1,1 then idle
    pop_byte(8'hA5, 0, 0);
    record(12);
    check("a5_line", packed_samp(12), 32'b010100101111);
    check("a5_busy", busy_n, 10);
    // 0x03 with parity
    pop_byte(8'h03, 1, 0);
    record(13);
    check("even_line", packed_samp(13), 32'b0110000000111);
    check("even_par", samp[9], 0);
    check("even_busy", busy_n, 11);
    pop_byte(8'h03, 1, 1);
    record(13);
    check("odd_par", samp[9], 1);
    check("odd_busy", busy_n, 11);
    // Two queued bytes go out back to back
    i_rdata = 8'h11; i_par_en = 0; i_empty = 0; ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (o_rinc === 1'b1) ok = 1;
    end
    check("pop1_wait", ok, 1);
    tick();
    i_rdata = 8'h22;
    n = 0; ok = 0;
    for (int i = 1; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (o_rinc === 1'b1) begin ok = 1; n = i; end
    end
    check("pop2_gap", n, 10);
    tick();
    i_empty = 1;
    pops = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 0) check("b2b_start", o_tx_out, 0);
      pops += (o_rinc === 1'b1) ? 1 : 0;
    end
    tick();
    check("extra_pops", pops, 0);
    // Reset during the 4th data bit of 0xFF
    pop_byte(8'hFF, 0, 0);
    repeat (4) tick();
    rst_n = 0; i_empty = 0; i_rdata = 8'h5A;
    @(negedge clk);
    check("rst_rinc", o_rinc, 0);
    tick();
    @(negedge clk);
    check("rst_tx", o_tx_out, 1);
    check("rst_busy", o_busy, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    check("rel_rinc", o_rinc, 1);
    tick();
    i_empty = 1;
    record(11);
    check("rel_line", packed_samp(11), 32'b00101101011);
`ifdef FIFO_UART_TX_PRESCALE_EN
    i_prescale = 4;
    pop_byte(8'h55, 0, 0);
    record(44);
    check("p4_busy", busy_n, 40);
    for (int i = 0; i < 40; i++) check("p4_bit", samp[i], (i / 4) % 2);
    i_prescale = 0;
    pop_byte(8'h55, 0, 0);
    record(12);
    check("p0_busy", busy_n, 10);
`endif
    // Random traffic, config churn and occasional resets
    for (int i = 0; i < 1500; i++) begin
      i_empty   = $urandom_range(9) < 4;
      i_rdata   = DW'($urandom);
      i_par_en  = $urandom_range(1);
      i_par_typ = $urandom_range(1);
      rst_n     = $urandom_range(199) != 0;
`ifdef FIFO_UART_TX_PRESCALE_EN
      i_prescale = PW'($urandom_range(3));
`endif
      tick();
    end
    rst_n = 1; i_empty = 1;
    repeat (60) tick();
    check("drained", o_busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
